gates4_rr_sched: RTL

GATES4_RR_SCHED -- requirements
Module: gates4_rr_sched

---
 rtl/gates4_rr_sched_if.sv | 29 ++
 rtl/gates4_rr_sched.sv | 129 ++++++++++++
 2 files changed

// File: rtl/gates4_rr_sched_if.sv
// Handshake bundle for gates4_rr_sched: two word requesters plus the reduction response.
// master = requester/consumer side, slave = the scheduler.
interface gates4_rr_sched_if #(parameter int NIBBLES = 4);
  localparam int W = 4 * NIBBLES;

  logic         req0_valid;
  logic [W-1:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [W-1:0] req1_data;
  logic         req1_ready;
  logic         rsp_valid;
  logic         rsp_id;
  logic         rsp_and;
  logic         rsp_or;
  logic         rsp_xor;
  logic         rsp_ready;
  logic         busy;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_and, rsp_or, rsp_xor, busy
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_and, rsp_or, rsp_xor, busy
  );
endinterface

// File: rtl/gates4_rr_sched.sv
// Round-robin scheduler sharing one 4-bit AND/OR/XOR reduction slice between two requesters.
// Optional per-requester completion counters: define GATES4_RR_SCHED_STATS_EN.
module gates4_rr_sched #(
  parameter int NIBBLES = 4
) (
  input logic clk,
  input logic reset,
  gates4_rr_sched_if.slave bus
`ifdef GATES4_RR_SCHED_STATS_EN
  ,
  output logic [15:0] stat_cnt0,
  output logic [15:0] stat_cnt1
`endif
);
  localparam int W = 4 * NIBBLES;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state;
  logic [W-1:0] data_q;
  logic [4:0]   cnt;
  logic         id_q;
  logic         last_id;
  logic         acc_and;
  logic         acc_or;
  logic         acc_xor;
  logic         busy_q;
  logic         rsp_valid_q;
  logic         rsp_id_q;
  logic         rsp_and_q;
  logic         rsp_or_q;
  logic         rsp_xor_q;
  logic         grant0;
  logic         grant1;
  logic [3:0]   nib;

  // The captured word shifts right each RUN cycle, so the low nibble is always the next one.
  assign nib = data_q[3:0];

  // Ties go to whoever was not served last; last_id resets to 1 so requester 0 wins first.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      grant0 = bus.req0_valid & (~bus.req1_valid | last_id);
      grant1 = bus.req1_valid & (~bus.req0_valid | ~last_id);
    end
  end

  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_and    = rsp_and_q;
  assign bus.rsp_or     = rsp_or_q;
  assign bus.rsp_xor    = rsp_xor_q;
  assign bus.busy       = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      data_q      <= '0;
      cnt         <= '0;
      id_q        <= 1'b0;
      last_id     <= 1'b1;
      acc_and     <= 1'b1;
      acc_or      <= 1'b0;
      acc_xor     <= 1'b0;
      busy_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_and_q   <= 1'b0;
      rsp_or_q    <= 1'b0;
      rsp_xor_q   <= 1'b0;
`ifdef GATES4_RR_SCHED_STATS_EN
      stat_cnt0   <= '0;
      stat_cnt1   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            data_q  <= grant1 ? bus.req1_data : bus.req0_data;
            id_q    <= grant1;
            cnt     <= '0;
            acc_and <= 1'b1;
            acc_or  <= 1'b0;
            acc_xor <= 1'b0;
            busy_q  <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          acc_and <= acc_and & (&nib);
          acc_or  <= acc_or  | (|nib);
          acc_xor <= acc_xor ^ (^nib);
          data_q  <= data_q >> 4;
          cnt     <= cnt + 5'd1;
          // The final nibble is folded straight into the response registers.
          if (cnt == 5'(NIBBLES - 1)) begin
            state       <= DONE;
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= id_q;
            rsp_and_q   <= acc_and & (&nib);
            rsp_or_q    <= acc_or  | (|nib);
            rsp_xor_q   <= acc_xor ^ (^nib);
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            last_id     <= rsp_id_q;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_and_q   <= 1'b0;
            rsp_or_q    <= 1'b0;
            rsp_xor_q   <= 1'b0;
`ifdef GATES4_RR_SCHED_STATS_EN
            if (!rsp_id_q && stat_cnt0 != 16'hFFFF) stat_cnt0 <= stat_cnt0 + 16'd1;
            if (rsp_id_q && stat_cnt1 != 16'hFFFF) stat_cnt1 <= stat_cnt1 + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
